// File: rtl/frame_transmitter.sv
// GMII frame transmitter: pops frame lengths from a show-ahead FIFO, streams bytes from
// a synchronous frame memory with preamble/SFD, optional padding to 60 bytes and CRC-32 FCS.
module frame_transmitter #(
  parameter int pADDR_W = 14,
  parameter int pLEN_W  = 11,
  parameter int pIFG    = 12,
  parameter int pPAD_EN = 1
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               i_pause,
  input  logic               i_fifo_empty,
  input  logic [pLEN_W-1:0]  i_fifo_len,
  output logic               o_fifo_rd,
  output logic [pADDR_W-1:0] o_rd_addr,
  input  logic [7:0]         i_rd_data,
  output logic               o_tx_en,
  output logic [7:0]         o_txd,
  output logic               o_tx_er,
  output logic [2:0]         o_state,
  output logic               o_drop
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    PAD      = 3'd4,
    FCS      = 3'd5,
    IFG      = 3'd6
  } state_t;

  localparam int PAD_TARGET = 60;
  localparam int MAX_LEN    = 1514;

  state_t             state, state_n;
  logic [15:0]        cnt, cnt_n;
  logic [pLEN_W-1:0]  len_q;
  logic [pADDR_W-1:0] ptr;
  logic [pADDR_W-1:0] rd_addr;
  logic [31:0]        crc;
  logic               fifo_rd;
  logic               drop;
  logic               tx_en_p1;
  logic [7:0]         txd_p1;
  logic               start;
  logic               bad;
  logic               last_data;
  logic               en_c;
  logic [7:0]         byte_c;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
    logic [31:0] f;
    f = ~c;
    return f[{idx, 3'b000} +: 8];
  endfunction

  // fifo_rd gates the start: the show-ahead head still shows the popped entry that cycle
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    en_c      = 1'b0;
    byte_c    = 8'h00;
    start     = (state == IDLE) && !i_fifo_empty && !i_pause && !fifo_rd;
    bad       = (i_fifo_len == '0) || (int'(i_fifo_len) > MAX_LEN);
    last_data = (int'(cnt) == int'(len_q) - 1);
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start && !bad) state_n = PREAMBLE;
      end
      PREAMBLE: begin
        en_c   = 1'b1;
        byte_c = 8'h55;
        if (cnt == 16'd6) begin
          state_n = SFD;
          cnt_n   = '0;
        end
      end
      SFD: begin
        en_c    = 1'b1;
        byte_c  = 8'hD5;
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: begin
        en_c   = 1'b1;
        byte_c = i_rd_data;
        if (last_data) begin
          if (pPAD_EN != 0 && int'(len_q) < PAD_TARGET) begin
            state_n = PAD;
          end else begin
            state_n = FCS;
            cnt_n   = '0;
          end
        end
      end
      PAD: begin
        en_c = 1'b1;
        if (int'(cnt) == PAD_TARGET - 1) begin
          state_n = FCS;
          cnt_n   = '0;
        end
      end
      FCS: begin
        en_c   = 1'b1;
        byte_c = fcs_byte(crc, cnt[1:0]);
        if (cnt == 16'd3) begin
          state_n = IFG;
          cnt_n   = '0;
        end
      end
      IFG: begin
        if (int'(cnt) == pIFG - 1) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // p1 output stage: GMII byte registered one cycle behind the state that produced it,
  // which lets DATA take the synchronous memory read straight from i_rd_data
  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      ptr      <= '0;
      rd_addr  <= '0;
      crc      <= '1;
      fifo_rd  <= 1'b0;
      drop     <= 1'b0;
      tx_en_p1 <= 1'b0;
      txd_p1   <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      fifo_rd  <= start;
      drop     <= start && bad;
      tx_en_p1 <= en_c;
      txd_p1   <= en_c ? byte_c : 8'h00;
      if (start) begin
        len_q   <= i_fifo_len;
        ptr     <= ptr + pADDR_W'(i_fifo_len);
        rd_addr <= ptr;
      end
      if (state == SFD || (state == DATA && !last_data)) rd_addr <= rd_addr + pADDR_W'(1);
      if (state == IDLE) crc <= '1;
      else if (state == DATA || state == PAD) crc <= crc_next(crc, byte_c);
    end
  end

  assign o_state   = state;
  assign o_fifo_rd = fifo_rd;
  assign o_drop    = drop;
  assign o_rd_addr = rd_addr;
  assign o_tx_en   = tx_en_p1;
  assign o_txd     = txd_p1;
  assign o_tx_er   = 1'b0;

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed bench for frame_transmitter: unpadded reference frame on one instance,
// padding, drops, address wrap, back-to-back spacing, pause and reset abort on another.
module tb_frame_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;

  logic        empty_a = 1'b1;
  logic [10:0] len_a = '0;
  logic        fifo_rd_a, tx_en_a, tx_er_a, drop_a;
  logic [13:0] addr_a;
  logic [7:0]  rd_data_a = '0, txd_a;
  logic [2:0]  state_a;

  logic        empty_b;
  logic [10:0] len_b;
  logic        fifo_rd_b, tx_en_b, tx_er_b, drop_b;
  logic [13:0] addr_b;
  logic [7:0]  rd_data_b = '0, txd_b;
  logic [2:0]  state_b;

  logic [7:0]  mem [16384];
  logic [10:0] fq [64];
  logic [5:0]  head = '0, tail = '0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  frame_transmitter #(.pPAD_EN(0)) dut_a (
    .iclk(clk), .i_rst(rst), .i_pause(pause), .i_fifo_empty(empty_a), .i_fifo_len(len_a),
    .o_fifo_rd(fifo_rd_a), .o_rd_addr(addr_a), .i_rd_data(rd_data_a), .o_tx_en(tx_en_a),
    .o_txd(txd_a), .o_tx_er(tx_er_a), .o_state(state_a), .o_drop(drop_a));

  frame_transmitter dut_b (
    .iclk(clk), .i_rst(rst), .i_pause(pause), .i_fifo_empty(empty_b), .i_fifo_len(len_b),
    .o_fifo_rd(fifo_rd_b), .o_rd_addr(addr_b), .i_rd_data(rd_data_b), .o_tx_en(tx_en_b),
    .o_txd(txd_b), .o_tx_er(tx_er_b), .o_state(state_b), .o_drop(drop_b));

  always @(posedge clk) begin
    rd_data_a <= mem[addr_a];
    rd_data_b <= mem[addr_b];
    if (fifo_rd_b) head <= head + 6'd1;
  end

  assign empty_b = (head == tail);
  assign len_b   = fq[head];

  // monitor for instance B
  logic [7:0]  cap [16384];
  int          fstart [64];
  int          fcap [64];
  int          gap [64];
  logic [13:0] sfd_addr [64];
  int cap_n = 0, nf_started = 0, nf_done = 0, nsfd = 0, ndrop = 0, low_run = 0, idle_bad = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (tx_en_b) begin
      if (!prev_en) begin
        fstart[nf_started] = cap_n;
        gap[nf_started]    = low_run;
        nf_started++;
        low_run = 0;
      end
      if (cap_n < 16384) cap[cap_n] = txd_b;
      cap_n++;
    end else begin
      if (txd_b != 8'h00) idle_bad++;
      if (prev_en) begin
        fcap[nf_done] = cap_n - fstart[nf_done];
        nf_done++;
      end
      low_run++;
    end
    if (state_b == 3'd2) begin
      sfd_addr[nsfd] = addr_b;
      nsfd++;
    end
    if (drop_b) ndrop++;
    prev_en = tx_en_b;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic push_len(input int l);
    fq[tail] = 11'(l);
    tail = tail + 6'd1;
  endtask

  task automatic wait_done(input int k, input int budget);
    for (int i = 0; i < budget && nf_done <= k; i++) @(negedge clk);
    check("frame_wait", nf_done > k, 1);
  endtask

  task automatic wait_drops(input int n, input int budget);
    for (int i = 0; i < budget && ndrop < n; i++) @(negedge clk);
    check("drop_count", ndrop, n);
  endtask

  task automatic verify_frame(input int k, input int len, input int start, input int en_exp,
                              input string tag);
    int s, n, bp, bd, bz;
    logic [31:0] c;
    s = fstart[k];
    n = fcap[k];
    bp = 0; bd = 0; bz = 0;
    check({tag, "_en_cycles"}, n, en_exp);
    check({tag, "_start_addr"}, int'(sfd_addr[k]), start);
    for (int i = 0; i < 8; i++) if (cap[s + i] != ((i < 7) ? 8'h55 : 8'hD5)) bp++;
    for (int i = 0; i < len && s + 8 + i < 16384; i++)
      if (cap[s + 8 + i] != mem[(start + i) % 16384]) bd++;
    for (int i = len; i < n - 12 && s + 8 + i < 16384; i++) if (cap[s + 8 + i] != 8'h00) bz++;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < n && s + i < 16384; i++) c = crc_upd(c, cap[s + i]);
    check({tag, "_preamble_bad"}, bp, 0);
    check({tag, "_data_bad"}, bd, 0);
    check({tag, "_pad_bad"}, bz, 0);
    check({tag, "_fcs_residue"}, c, 32'hDEBB_20E3);
  endtask

  typedef struct {
    int len;
    int en_cycles;
  } vec_t;
  vec_t vecs [6];

  logic [7:0] exp_a [21];
  logic [7:0] got_a [64];
  int exp_ptr, fk, na;

  initial begin
    vecs[0] = '{20, 72};
    vecs[1] = '{60, 72};
    vecs[2] = '{59, 72};
    vecs[3] = '{61, 73};
    vecs[4] = '{1, 72};
    vecs[5] = '{1514, 1526};
    for (int i = 0; i < 16384; i++) mem[i] = 8'((i * 13 + 7) & 255);
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 7; i++) exp_a[i] = 8'h55;
    exp_a[7] = 8'hD5;
    for (int i = 0; i < 9; i++) exp_a[8 + i] = 8'h31 + 8'(i);
    exp_a[17] = 8'h26; exp_a[18] = 8'h39; exp_a[19] = 8'hF4; exp_a[20] = 8'hCB;
    for (int i = 0; i < 64; i++) got_a[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_state", state_b, 0);
    check("rst_tx_en", tx_en_b, 0);
    check("rst_txd", txd_b, 0);
    check("rst_fifo_rd", fifo_rd_b, 0);
    check("rst_drop", drop_b, 0);
    check("rst_addr", addr_b, 0);
    check("rst_tx_er", tx_er_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // unpadded "123456789" reference frame
    empty_a = 1'b0;
    len_a   = 11'd9;
    for (int i = 0; i < 20 && !fifo_rd_a; i++) @(negedge clk);
    check("a_pop", fifo_rd_a, 1);
    empty_a = 1'b1;
    for (int i = 0; i < 20 && !tx_en_a; i++) @(negedge clk);
    na = 0;
    while (tx_en_a && na < 40) begin
      got_a[na] = txd_a;
      na++;
      @(negedge clk);
    end
    check("a_en_cycles", na, 21);
    for (int i = 0; i < 21; i++) check($sformatf("a_byte%0d", i), got_a[i], exp_a[i]);
    check("a_tx_er", tx_er_a, 0);

    // drops: zero length then oversize, nothing transmitted
    push_len(0);
    push_len(1600);
    wait_drops(2, 40);
    repeat (20) @(negedge clk);
    check("drop_no_tx", nf_started, 0);
    exp_ptr = 1600;
    for (int i = 0; i < 4; i++) push_len(1847);
    for (int i = 0; i < 4; i++) push_len(1848);
    wait_drops(10, 100);
    exp_ptr = 16380;

    // address wrap at the top of memory
    fk = 0;
    push_len(8);
    wait_done(fk, 400);
    verify_frame(fk, 8, exp_ptr, 72, "wrap");
    fk++;
    exp_ptr = 4;

    for (int v = 0; v < 6; v++) begin
      push_len(vecs[v].len);
      wait_done(fk, 3000);
      verify_frame(fk, vecs[v].len, exp_ptr, vecs[v].en_cycles, $sformatf("vec%0d", v));
      fk++;
      exp_ptr = (exp_ptr + vecs[v].len) % 16384;
    end

    // back-to-back frames
    push_len(64);
    push_len(64);
    wait_done(fk + 1, 800);
    verify_frame(fk, 64, exp_ptr, 76, "b2b_first");
    verify_frame(fk + 1, 64, exp_ptr + 64, 76, "b2b_second");
    check("b2b_gap", gap[fk + 1], 13);
    fk += 2;
    exp_ptr += 128;

    // pause holds off the start of a queued frame
    pause = 1'b1;
    push_len(30);
    repeat (40) @(negedge clk);
    check("pause_no_start", nf_started, fk);
    check("pause_not_popped", empty_b, 0);
    pause = 1'b0;
    wait_done(fk, 400);
    verify_frame(fk, 30, exp_ptr, 72, "pause");
    fk++;
    exp_ptr += 30;

    // asynchronous reset in the middle of DATA
    push_len(100);
    for (int i = 0; i < 60 && state_b != 3'd3; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_tx_en", tx_en_b, 0);
    check("abort_txd", txd_b, 0);
    check("abort_state", state_b, 0);
    check("abort_addr", addr_b, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(fk, 10);
    check("abort_short", fcap[fk] > 8 && fcap[fk] < 108, 1);
    fk++;
    exp_ptr = 0;
    repeat (3) @(negedge clk);
    push_len(30);
    wait_done(fk, 400);
    verify_frame(fk, 30, exp_ptr, 72, "after_rst");

    check("txd_idle_zero", idle_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
